// File: rtl/perfmon_pkg.sv
// Shared types and encodings for the W-stage performance monitor.
package perfmon_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } pm_state_t;

    localparam logic [5:0] OP_PM_CYC = 6'b111111;
    localparam logic [5:0] OP_PM_INS = 6'b111110;

    localparam logic PM_CYC = 1'b1;
    localparam logic PM_INS = 1'b0;

endpackage

// File: rtl/pm_sat_counter.sv
// Saturating up-counter; sat pulses when an increment is attempted at the maximum value.
module pm_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic at_max;

    assign at_max = (count == CNT_MAX);
    assign sat    = inc && !clr && at_max;

    // Clear wins over increment; at the maximum the value simply holds.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/perfmon_unit.sv
// Perfmon FSM: arms a cycle/instruction counter on one perfmon instruction and
// returns the count through the writeback mux on the next.
module perfmon_unit
    import perfmon_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             perfmon_enW,
    input  logic             perfmon_typeW,
    input  logic             instr_retW,
    output logic             pm_wb_sel,
    output logic [CNT_W-1:0] pm_wb_data,
    output logic             pm_busy,
    output logic             pm_mode,
    output logic             pm_ovf
);

    pm_state_t        state;
    pm_state_t        next_state;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             cnt_sat;
    logic [CNT_W-1:0] count;

    pm_sat_counter #(.CNT_W(CNT_W)) u_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (count),
        .sat   (cnt_sat)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A matching type stops the measurement; a differing type restarts it in place.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (perfmon_enW) next_state = COUNT;
            COUNT:   if (perfmon_enW && (perfmon_typeW == pm_mode)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Start/stop cycles are never counted, so increments only happen with no perfmon in W.
    always_comb begin
        pm_wb_sel  = perfmon_enW;
        pm_wb_data = '0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        if (state == COUNT) begin
            if (perfmon_enW) begin
                pm_wb_data = count;
                cnt_clr    = (perfmon_typeW != pm_mode);
            end else begin
                cnt_inc = (pm_mode == PM_CYC) || instr_retW;
            end
        end else begin
            cnt_clr = perfmon_enW;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pm_mode <= PM_INS;
            pm_ovf  <= 1'b0;
        end else if (cnt_clr) begin
            pm_mode <= perfmon_typeW;
            pm_ovf  <= 1'b0;
        end else if (cnt_sat) begin
            pm_ovf  <= 1'b1;
        end
    end

    assign pm_busy = (state == COUNT);

endmodule

// File: tb/tb_perfmon_unit.sv
// Directed vector bench for perfmon_unit (32-bit main instance, 4-bit instance for saturation).
module tb_perfmon_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        perfmon_enW, perfmon_typeW, instr_retW;
    logic        pm_wb_sel, pm_busy, pm_mode, pm_ovf;
    logic [31:0] pm_wb_data;

    logic        en4, typ4, ret4;
    logic        sel4, busy4, mode4, ovf4;
    logic [3:0]  data4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        int          reps;
        logic        rst;
        logic        en;
        logic        typ;
        logic        ret;
        logic        sel;
        logic [31:0] data;
        logic        busy;
        logic        mode;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    perfmon_unit #(.CNT_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .perfmon_enW   (perfmon_enW),
        .perfmon_typeW (perfmon_typeW),
        .instr_retW    (instr_retW),
        .pm_wb_sel     (pm_wb_sel),
        .pm_wb_data    (pm_wb_data),
        .pm_busy       (pm_busy),
        .pm_mode       (pm_mode),
        .pm_ovf        (pm_ovf)
    );

    perfmon_unit #(.CNT_W(4)) dut4 (
        .clk           (clk),
        .reset         (reset),
        .perfmon_enW   (en4),
        .perfmon_typeW (typ4),
        .instr_retW    (ret4),
        .pm_wb_sel     (sel4),
        .pm_wb_data    (data4),
        .pm_busy       (busy4),
        .pm_mode       (mode4),
        .pm_ovf        (ovf4)
    );

    always #5 clk = ~clk;

    function automatic void checkVal(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void checkOutput(string name, logic sel, logic [31:0] data,
                                        logic busy, logic mode, logic ovf);
        checkVal({name, ".sel"},  {31'b0, pm_wb_sel}, {31'b0, sel});
        checkVal({name, ".data"}, pm_wb_data, data);
        checkVal({name, ".busy"}, {31'b0, pm_busy}, {31'b0, busy});
        checkVal({name, ".mode"}, {31'b0, pm_mode}, {31'b0, mode});
        checkVal({name, ".ovf"},  {31'b0, pm_ovf},  {31'b0, ovf});
    endfunction

    function automatic void checkOutput4(string name, logic sel, logic [3:0] data,
                                         logic busy, logic ovf);
        checkVal({name, ".sel"},  {31'b0, sel4}, {31'b0, sel});
        checkVal({name, ".data"}, {28'b0, data4}, {28'b0, data});
        checkVal({name, ".busy"}, {31'b0, busy4}, {31'b0, busy});
        checkVal({name, ".ovf"},  {31'b0, ovf4},  {31'b0, ovf});
    endfunction

    // Inputs change on the falling edge and are sampled 2 time units later.
    task automatic applyStimulus(logic rst, logic en, logic typ, logic ret);
        @(negedge clk);
        reset         = rst;
        perfmon_enW   = en;
        perfmon_typeW = typ;
        instr_retW    = ret;
        #2;
    endtask

    task automatic applyStimulus4(logic en, logic typ, logic ret);
        @(negedge clk);
        en4  = en;
        typ4 = typ;
        ret4 = ret;
        #2;
    endtask

    function automatic void addVec(string name, int reps, logic rst, logic en, logic typ,
                                   logic ret, logic sel, logic [31:0] data, logic busy,
                                   logic mode, logic ovf);
        vec_t v;
        v.name = name; v.reps = reps; v.rst = rst; v.en = en; v.typ = typ; v.ret = ret;
        v.sel = sel; v.data = data; v.busy = busy; v.mode = mode; v.ovf = ovf;
        vecs.push_back(v);
    endfunction

    initial begin
        reset = 1'b0; perfmon_enW = 1'b0; perfmon_typeW = 1'b0; instr_retW = 1'b0;
        en4 = 1'b0; typ4 = 1'b0; ret4 = 1'b0;

        //      name          reps rst en typ ret  sel data busy mode ovf
        addVec("reset_state",  9,  1, 0, 0, 0,   0, 0,   0,   0,   0);
        addVec("cyc_start",    1,  1, 1, 1, 0,   1, 0,   0,   0,   0);
        addVec("cyc_run",      9,  1, 0, 0, 0,   0, 0,   1,   1,   0);
        addVec("cyc_stop",     1,  1, 1, 1, 0,   1, 9,   1,   1,   0);
        addVec("cyc_after",    1,  1, 0, 0, 0,   0, 0,   0,   1,   0);
        addVec("ins_start",    1,  1, 1, 0, 0,   1, 0,   0,   1,   0);
        addVec("ins_r1",       1,  1, 0, 0, 1,   0, 0,   1,   0,   0);
        addVec("ins_r0",       1,  1, 0, 0, 0,   0, 0,   1,   0,   0);
        addVec("ins_r1",       2,  1, 0, 0, 1,   0, 0,   1,   0,   0);
        addVec("ins_r0",       1,  1, 0, 0, 0,   0, 0,   1,   0,   0);
        addVec("ins_r1",       2,  1, 0, 0, 1,   0, 0,   1,   0,   0);
        addVec("ins_stop",     1,  1, 1, 0, 1,   1, 5,   1,   0,   0);
        addVec("idle_ret",     3,  1, 0, 0, 1,   0, 0,   0,   0,   0);
        addVec("rst_start",    1,  1, 1, 1, 0,   1, 0,   0,   0,   0);
        addVec("rst_run",      4,  1, 0, 0, 0,   0, 0,   1,   1,   0);
        addVec("restart",      1,  1, 1, 0, 0,   1, 4,   1,   1,   0);
        addVec("restart_ret",  3,  1, 0, 0, 1,   0, 0,   1,   0,   0);
        addVec("restart_stop", 1,  1, 1, 0, 0,   1, 3,   1,   0,   0);
        addVec("restart_idle", 1,  1, 0, 0, 0,   0, 0,   0,   0,   0);
        addVec("cycret_start", 1,  1, 1, 1, 0,   1, 0,   0,   0,   0);
        addVec("cycret_run",   3,  1, 0, 0, 1,   0, 0,   1,   1,   0);
        addVec("cycret_stop",  1,  1, 1, 1, 1,   1, 3,   1,   1,   0);
        addVec("mid_start",    1,  1, 1, 1, 0,   1, 0,   0,   1,   0);
        addVec("mid_run",      5,  1, 0, 0, 0,   0, 0,   1,   1,   0);
        addVec("mid_reset",    1,  0, 0, 0, 0,   0, 0,   1,   1,   0);
        addVec("mid_after",    1,  1, 0, 0, 0,   0, 0,   0,   0,   0);
        addVec("mid_restart",  1,  1, 1, 1, 0,   1, 0,   0,   0,   0);
        addVec("mid_run2",     2,  1, 0, 0, 0,   0, 0,   1,   1,   0);
        addVec("mid_stop",     1,  1, 1, 1, 0,   1, 2,   1,   1,   0);
        addVec("mid_idle",     1,  1, 0, 0, 0,   0, 0,   0,   1,   0);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].typ, vecs[i].ret);
                checkOutput(vecs[i].name, vecs[i].sel, vecs[i].data,
                            vecs[i].busy, vecs[i].mode, vecs[i].ovf);
            end
        end

        // Background retire traffic with no perfmon instruction must never drive the mux.
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
            checkVal("quiet.sel",  {31'b0, pm_wb_sel}, 32'd0);
            checkVal("quiet.data", pm_wb_data, 32'd0);
        end

        // 4-bit saturation: 20 running cycles, increments beyond 15 only set the sticky flag.
        applyStimulus4(1'b1, 1'b1, 1'b0);
        checkOutput4("sat_start", 1'b1, 4'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            applyStimulus4(1'b0, 1'b0, 1'b0);
            checkOutput4("sat_run", 1'b0, 4'd0, 1'b1, (i >= 17));
        end
        applyStimulus4(1'b1, 1'b1, 1'b0);
        checkOutput4("sat_stop", 1'b1, 4'd15, 1'b1, 1'b1);
        applyStimulus4(1'b0, 1'b0, 1'b0);
        checkOutput4("sat_idle", 1'b0, 4'd0, 1'b0, 1'b1);
        applyStimulus4(1'b1, 1'b1, 1'b0);
        checkOutput4("sat_restart", 1'b1, 4'd0, 1'b0, 1'b1);
        applyStimulus4(1'b0, 1'b0, 1'b0);
        checkOutput4("sat_cleared", 1'b0, 4'd0, 1'b1, 1'b0);
        applyStimulus4(1'b1, 1'b1, 1'b0);
        checkOutput4("sat_short", 1'b1, 4'd1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/perfmon_unit.md
# perfmon_unit

Performance-monitor unit for the five-stage MIPS pipeline. It consumes the decoder's `perfmon_en` / `perfmon_type` flags, aligned to the writeback (W) stage, together with a per-cycle retire strobe. A first perfmon instruction arms a cycle or instruction counter; the next one stops it and returns the count through the writeback mux into the destination register. It sits directly downstream of the controller, alongside the W-stage register-write path.

## Interface
Parameters:
- `CNT_W`, default 32: counter and result width; must equal the register-file data width.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `perfmon_enW`  in  1  perfmon instruction present in W this cycle.
- `perfmon_typeW`  in  1  1 = count cycles (op 111111), 0 = count retired instructions (op 111110); valid when `perfmon_enW`=1.
- `instr_retW`  in  1  a non-bubble instruction retires in W this cycle.
- `pm_wb_sel`  out  1  writeback mux select; forces `pm_wb_data` onto the register write data this cycle.
- `pm_wb_data`  out  CNT_W  count value returned to the register file.
- `pm_busy`  out  1  counter armed.
- `pm_mode`  out  1  latched type of the armed measurement.
- `pm_ovf`  out  1  sticky saturation flag for the current or last measurement.

## Operation
- States:
  - `IDLE`: nothing armed.
  - `COUNT`: counter armed.
- IDLE, `perfmon_enW`=1:
  - Go to COUNT.
  - Latch `pm_mode` <= `perfmon_typeW`; count <= 0; `pm_ovf` <= 0.
  - `pm_wb_sel`=1 and `pm_wb_data`=0, so the start instruction writes 0 to rd.
- COUNT, `perfmon_enW`=0:
  - Cycle mode: count increments by 1 every cycle.
  - Instruction mode: count increments by 1 only when `instr_retW`=1.
- COUNT, `perfmon_enW`=1, type equal to `pm_mode` (stop):
  - `pm_wb_sel`=1, `pm_wb_data`=count (pre-increment value).
  - Go to IDLE. Count holds its value; `pm_ovf` holds.
  - No increment on the stop cycle, in either mode.
- COUNT, `perfmon_enW`=1, type different from `pm_mode` (restart):
  - `pm_wb_sel`=1, `pm_wb_data`=current count.
  - Stay in COUNT, latch the new mode, count <= 0, `pm_ovf` <= 0.
- Saturation: count stops at 2^CNT_W−1; an increment attempted at max sets `pm_ovf`=1 and leaves count unchanged.
- Start and stop cycles never count themselves; the result counts only events strictly between them.
- `instr_retW` is ignored in IDLE and in cycle mode.

## Timing
- Reset (`reset`=0 at a rising edge) forces:
  - state=IDLE, count=0, `pm_mode`=0, `pm_ovf`=0.
  - Outputs: `pm_busy`=0, `pm_wb_sel`=0, `pm_wb_data`=0.
- Reset mid-measurement discards the count; a stop perfmon arriving after reset is treated as a start.
- `pm_wb_sel` and `pm_wb_data` are combinational from `perfmon_enW`, state and the count register: zero-latency, same cycle as the W-stage instruction.
- `pm_busy`, `pm_mode` and `pm_ovf` are registered and change the cycle after the triggering edge.
- Cycle mode: start in W at cycle t, stop in W at cycle t+N → result N−1.
- `pm_wb_data`=0 whenever `pm_wb_sel`=0.
- No handshake: the W stage never stalls, so every `perfmon_enW` pulse is consumed in its cycle.

## Structure
- Shared package `perfmon_pkg`:
  - State enum `pm_state_t` {IDLE, COUNT}.
  - Opcodes `OP_PM_CYC`=6'b111111 and `OP_PM_INS`=6'b111110.
  - Type encoding `PM_CYC`=1, `PM_INS`=0.
- Sub-module `pm_sat_counter`:
  - Parameterised CNT_W.
  - Inputs: `clr`, `inc`.
  - Outputs: count, `sat` pulse.
- `perfmon_unit` holds the FSM, mode/overflow registers and the wb mux outputs.

## Test plan
- Cycle measure: reset, start type=1 at cycle 10, stop type=1 at cycle 20 → `pm_wb_sel`=1 at both cycles; `pm_wb_data`=0 at cycle 10, 9 at cycle 20; `pm_busy` 1 for cycles 11–20, then 0.
- Instruction measure: start type=0, then 7 cycles with `instr_retW` pattern 1,0,1,1,0,1,1, then stop → result 5; cycles without `instr_retW` add nothing.
- Restart: start type=1, 4 idle cycles, then type=0 → returns 4, `pm_mode`=0, count cleared; 3 retires, then stop type=0 → returns 3.
- Saturation (CNT_W=4): start cycle mode, wait 20 cycles, stop → result 15, `pm_ovf`=1; next start clears `pm_ovf` to 0.
- Reset mid-operation: start, 5 cycles, assert `reset`=0 for one cycle → `pm_busy`=0, count=0; next perfmon acts as a start and returns 0.
- No-perfmon traffic: 100 cycles of random `instr_retW` with `perfmon_enW`=0 → `pm_wb_sel`=0 and `pm_wb_data`=0 throughout.
